mmix_mem_port: RTL and testbench

- Memory-side adapter directly downstream of the load/store unit.
- Accepts its 64-bit, big-endian, size-tagged request (mem_address/mem_datasize/mem_read/mem_write) and drives a 32-bit Avalon-MM master toward SDRAM/on-chip RAM.
- Octa accesses are split into two tetra beats. Byte and wyde accesses use byte lanes.
- Returns right-justified read data and a one-cycle mem_done pulse.

---
 rtl/mmix_mem_port.sv | 172 +++++++++++++++++
 tb/tb_mmix_mem_port.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmix_mem_port.sv
// Memory-side adapter: turns one size-tagged, big-endian 64-bit load/store
// request into one or two 32-bit Avalon-MM beats. It returns right-justified,
// zero-extended read data and a one-cycle completion pulse.
module mmix_mem_port #(
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state_reg, state_next;
  logic              beat_reg, beat_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [63:0]       wdata_reg;
  logic              is_read_reg;
  logic [63:0]       result_reg, result_next;
  logic [ADDR_W-1:0] align_mask;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic [1:0]        lane_sel;
  logic [7:0]        rd_byte [4];
  logic              in_req;
  logic              last_beat;
  logic              unused_addr_hi;

  // Address bits above the bus width are dropped on purpose.
  assign unused_addr_hi = ^mem_address[63:ADDR_W];

  // Lane 3 holds the lowest byte address (big-endian), lane 0 the highest.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = avm_readdata[8*gi +: 8];
  end

  assign in_req    = (state_reg == REQ);
  assign lane_sel  = 2'd3 - addr_reg[1:0];
  // Only the first beat of an octa is followed by a second one.
  assign last_beat = !((size_reg == 2'd3) && !beat_reg);

  // Natural alignment for the incoming request size.
  always_comb begin
    case (mem_datasize)
      2'd0:    align_mask = '1;
      2'd1:    align_mask = {{(ADDR_W-1){1'b1}}, 1'b0};
      2'd2:    align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};
      default: align_mask = {{(ADDR_W-3){1'b1}}, 3'b000};
    endcase
  end

  // Byte-lane enables and replicated write data for the current beat.
  always_comb begin
    case (size_reg)
      2'd0: begin
        lane_be    = 4'b1000 >> addr_reg[1:0];
        lane_wdata = {4{wdata_reg[7:0]}};
      end
      2'd1: begin
        lane_be    = addr_reg[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{wdata_reg[15:0]}};
      end
      2'd2: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_reg[31:0];
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = beat_reg ? wdata_reg[31:0] : wdata_reg[63:32];
      end
    endcase
  end

  // Bus command is only presented in REQ; everything else is quiet zero.
  assign avm_read       = in_req && is_read_reg;
  assign avm_write      = in_req && !is_read_reg;
  assign avm_byteenable = in_req ? lane_be : 4'b0000;
  assign avm_writedata  = in_req ? lane_wdata : 32'd0;
  assign avm_address    = in_req ? {addr_reg[ADDR_W-1:3], addr_reg[2] | beat_reg, 2'b00}
                                 : '0;
  assign mem_done       = (state_reg == DONE);
  assign mem_readdata   = result_reg;

  // Transaction sequencing: one outstanding request, octa as two beats.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_next = REQ;
          beat_next  = 1'b0;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          if (is_read_reg) begin
            state_next = RESP;
          end else if (!last_beat) begin
            beat_next = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      RESP: begin
        if (avm_readdatavalid) begin
          if (!last_beat) begin
            state_next = REQ;
            beat_next  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Right-justify returned lanes into the result register.
  always_comb begin
    result_next = result_reg;
    if ((state_reg == RESP) && avm_readdatavalid) begin
      case (size_reg)
        2'd0:    result_next = {56'd0, rd_byte[lane_sel]};
        2'd1:    result_next = {48'd0, addr_reg[1] ? avm_readdata[15:0] : avm_readdata[31:16]};
        2'd2:    result_next = {32'd0, avm_readdata};
        default: result_next = beat_reg ? {result_reg[63:32], avm_readdata}
                                         : {avm_readdata, result_reg[31:0]};
      endcase
    end
  end

  // State, beat, latched request and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      beat_reg    <= 1'b0;
      addr_reg    <= '0;
      size_reg    <= 2'd0;
      wdata_reg   <= 64'd0;
      is_read_reg <= 1'b0;
      result_reg  <= 64'd0;
    end else begin
      state_reg  <= state_next;
      beat_reg   <= beat_next;
      result_reg <= result_next;
      if ((state_reg == IDLE) && (mem_read || mem_write)) begin
        addr_reg    <= mem_address[ADDR_W-1:0] & align_mask;
        size_reg    <= mem_datasize;
        wdata_reg   <= mem_writedata;
        is_read_reg <= mem_read;
      end
    end
  end

endmodule

// File: tb/tb_mmix_mem_port.sv
// Scoreboard bench for mmix_mem_port: byte-addressed reference memory,
// Avalon slave model with stalls/latency, and decoupled bus/done monitors.
module tb_mmix_mem_port;
  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       mem_address, mem_writedata, mem_readdata;
  logic [1:0]        mem_datasize;
  logic              mem_read, mem_write, mem_done;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata, avm_readdata;
  logic              avm_readdatavalid, avm_waitrequest;

  mmix_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_datasize(mem_datasize),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [ADDR_W-1:0] addr; logic [3:0] be; bit wr; } beat_t;
  typedef struct { logic [63:0] data; bit rd; } done_t;
  beat_t beat_q[$];
  done_t done_q[$];

  byte unsigned rmem[int];   // reference model memory
  byte unsigned smem[int];   // slave-side memory
  logic [63:0]  last_read = 64'd0;

  // slave configuration
  int wait_mode = 0;         // 0 none, 1 random, 2 fixed count per command
  int wait_fixed = 0;
  int rdv_min = 1, rdv_max = 1;
  bit spurious_en = 0;

  // slave / monitor state
  int stall_cnt = 0, stall_cycles = 0;
  int bus_accepts = 0, bus_writes = 0, done_cnt = 0;
  bit rd_pending = 0;
  int rd_cnt = 0;
  int rd_addr = 0;
  bit have_snap = 0;
  logic [61:0] snap, cur;
  logic [31:0] last_wdata = 32'd0;
  bit wr_now;
  beat_t eb;
  done_t ed;

  function automatic byte unsigned init_byte(int a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction
  function automatic byte unsigned rbyte(int a);
    return rmem.exists(a) ? rmem[a] : init_byte(a);
  endfunction
  function automatic byte unsigned sbyte(int a);
    return smem.exists(a) ? smem[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] slave_word(int a);
    return {sbyte(a), sbyte(a + 1), sbyte(a + 2), sbyte(a + 3)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic poke(input int a, input byte unsigned b);
    rmem[a] = b;
    smem[a] = b;
  endtask

  // Avalon slave model + bus-side checks, evaluated on the falling edge.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    if (reset) begin
      rd_pending = 0;
      have_snap = 0;
      stall_cnt = 0;
      avm_waitrequest = 1'b0;
    end else begin
      if (rd_pending) begin
        if (rd_cnt <= 1) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = slave_word(rd_addr);
          rd_pending = 0;
        end else rd_cnt--;
      end else if (spurious_en && $urandom_range(0, 5) == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = $urandom;
      end
      cur = {avm_read, avm_write, avm_address, avm_byteenable, avm_writedata};
      if (have_snap) begin
        check("stall_hold", 64'(cur), 64'(snap));
        have_snap = 0;
      end
      if (avm_read || avm_write) begin
        case (wait_mode)
          1: wr_now = ($urandom_range(0, 2) == 0);
          2: wr_now = (stall_cnt < wait_fixed);
          default: wr_now = 0;
        endcase
        if (wr_now) begin
          stall_cnt++;
          stall_cycles++;
          snap = cur;
          have_snap = 1;
        end else begin
          stall_cnt = 0;
          bus_accepts++;
          if (avm_write) begin
            bus_writes++;
            last_wdata = avm_writedata;
          end
          if (beat_q.size() == 0) begin
            check("unexpected_beat", 64'(avm_address), 64'hFFFF_FFFF);
          end else begin
            eb = beat_q.pop_front();
            check("beat_addr", 64'(avm_address), 64'(eb.addr));
            check("beat_be", 64'(avm_byteenable), 64'(eb.be));
            check("beat_dir", 64'(avm_write), 64'(eb.wr));
          end
          if (avm_write) begin
            for (int l = 0; l < 4; l++)
              if (avm_byteenable[l]) smem[int'(avm_address) + 3 - l] = avm_writedata[8*l +: 8];
          end else begin
            rd_pending = 1;
            rd_cnt = $urandom_range(rdv_min, rdv_max);
            rd_addr = int'(avm_address);
          end
        end
      end else begin
        wr_now = (wait_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
      avm_waitrequest = wr_now;
    end
  end

  // Completion monitor: pops the scoreboard on every mem_done pulse.
  always @(negedge clk) begin
    if (!reset && mem_done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        check("unexpected_done", 64'(mem_done), 64'd0);
      end else begin
        ed = done_q.pop_front();
        check(ed.rd ? "read_data" : "write_keeps_data", mem_readdata, ed.data);
        $display("[TB] done %s data=%h", ed.rd ? "read " : "write", mem_readdata);
      end
    end
  end

  // Push expectations from the reference model and present the request.
  task automatic start_req(input bit rd, input bit wr, input logic [1:0] sz,
                           input logic [63:0] addr, input logic [63:0] wd);
    int n, a, t;
    bit is_rd;
    beat_t e;
    done_t d;
    logic [63:0] v;
    n = 1 << sz;
    a = int'(addr[ADDR_W-1:0]) & ~(n - 1);
    is_rd = rd;
    for (int b = 0; b < ((sz == 2'd3) ? 2 : 1); b++) begin
      t = (a & ~3) + 4 * b;
      e.be = 4'b0000;
      for (int i = 0; i < n; i++)
        if (((a + i) & ~3) == t) e.be[3 - ((a + i) & 3)] = 1'b1;
      e.addr = ADDR_W'(t);
      e.wr = !is_rd;
      beat_q.push_back(e);
    end
    if (is_rd) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(rbyte(a + i));
      last_read = v;
    end else begin
      for (int i = 0; i < n; i++) rmem[a + i] = 8'(wd >> (8 * (n - 1 - i)));
    end
    d.data = last_read;
    d.rd = is_rd;
    done_q.push_back(d);
    mem_read = rd;
    mem_write = wr;
    mem_datasize = sz;
    mem_address = addr;
    mem_writedata = wd;
  endtask

  // Hold the request until mem_done, keep it through DONE, return after it.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
      if (mem_done) break;
      if (lat > 400) begin
        check("done_timeout", 64'(lat), 64'd0);
        finish_run();
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [1:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd, output int lat);
    start_req(rd, wr, sz, addr, wd);
    wait_done(lat);
  endtask

  task automatic drop(input int k);
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int lat, b0, d0, w0, s0, n;
    logic [63:0] addr;
    reset = 1'b1;
    mem_read = 0; mem_write = 0; mem_datasize = 0;
    mem_address = 0; mem_writedata = 0;
    avm_readdata = 0; avm_readdatavalid = 0; avm_waitrequest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_bus", 64'({avm_read, avm_write, mem_done, avm_byteenable, avm_address, avm_writedata}), 64'd0);
    check("reset_readdata", mem_readdata, 64'd0);
    reset = 1'b0;
    drop(2);

    // 1: byte write, latency 2, lane 0 enabled, replicated data
    issue(0, 1, 2'd0, 64'h1003, 64'hAB, lat);
    check("t1_latency", 64'(lat), 64'd2);
    check("t1_wdata", 64'(last_wdata), 64'hABABABAB);
    drop(1);

    // 2: octa read at 0x2005, two beats, latency 5
    for (int i = 0; i < 8; i++) begin
      addr = 64'h0123456789ABCDEF;
      poke(32'h2000 + i, addr[63 - 8*i -: 8]);
    end
    issue(1, 0, 2'd3, 64'h2005, 64'd0, lat);
    check("t2_latency", 64'(lat), 64'd5);
    check("t2_readdata", mem_readdata, 64'h0123456789ABCDEF);
    drop(1);

    // 3: wyde read with 3 stall cycles
    poke(32'h10, 8'hBE); poke(32'h11, 8'hEF); poke(32'h12, 8'h12); poke(32'h13, 8'h34);
    wait_mode = 2; wait_fixed = 3; s0 = stall_cycles;
    issue(1, 0, 2'd1, 64'h10, 64'd0, lat);
    check("t3_stalls", 64'(stall_cycles - s0), 64'd3);
    check("t3_readdata", mem_readdata, 64'hBEEF);
    wait_mode = 0;
    drop(1);

    // latency table for all sizes, both directions
    for (int sz = 0; sz < 4; sz++) begin
      for (int rd = 0; rd < 2; rd++) begin
        issue(rd[0], !rd[0], 2'(sz), 64'h3000 + 64'(sz * 16) + 64'd2, {$urandom, $urandom}, lat);
        check("size_latency", 64'(lat), 64'((sz == 3 ? 2 : 1) * (rd == 1 ? 2 : 1) + 1));
        drop(1);
      end
    end

    // 4: read held through DONE then dropped -> one bus read, one done
    b0 = bus_accepts; d0 = done_cnt;
    issue(1, 0, 2'd2, 64'h1000, 64'd0, lat);
    drop(4);
    check("t4_bus_reads", 64'(bus_accepts - b0), 64'd1);
    check("t4_dones", 64'(done_cnt - d0), 64'd1);

    // 5: read and write both high -> read only
    w0 = bus_writes;
    issue(1, 1, 2'd2, 64'h2004, 64'h5555AAAA5555AAAA, lat);
    check("t5_no_write", 64'(bus_writes - w0), 64'd0);
    drop(1);

    // 6: reset during RESP of octa beat 0
    rdv_min = 6; rdv_max = 6;
    b0 = bus_accepts;
    start_req(1, 0, 2'd3, 64'h2000, 64'd0);
    n = 0;
    while (bus_accepts == b0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("t6_first_beat", 64'(bus_accepts - b0), 64'd1);
    @(negedge clk); #1;
    reset = 1'b1;
    mem_read = 1'b0;
    beat_q.delete();
    done_q.delete();
    last_read = 64'd0;
    d0 = done_cnt;
    @(negedge clk); #1;
    check("t6_bus_idle", 64'({avm_read, avm_write, mem_done, avm_byteenable, avm_address, avm_writedata}), 64'd0);
    check("t6_readdata", mem_readdata, 64'd0);
    reset = 1'b0;
    rdv_min = 1; rdv_max = 1;
    drop(4);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    issue(1, 0, 2'd2, 64'h2000, 64'd0, lat);
    check("t6_after_latency", 64'(lat), 64'd3);
    drop(1);

    // randomized traffic with stalls, variable latency and spurious strobes
    wait_mode = 1; rdv_min = 1; rdv_max = 3; spurious_en = 1;
    for (int k = 0; k < 200; k++) begin
      int r;
      r = $urandom_range(0, 4);
      addr = {$urandom, $urandom};
      addr[ADDR_W-1:0] = ADDR_W'(32'h400 + $urandom_range(0, 47));
      issue(r != 1 && r != 3, r == 1 || r == 3 || r == 4, 2'($urandom_range(0, 3)),
            addr, {$urandom, $urandom}, lat);
      if ($urandom_range(0, 1) == 0) drop($urandom_range(1, 2));
    end
    drop(10);
    check("beat_q_empty", 64'(beat_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    finish_run();
  end

endmodule
